coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable samples needed to accept a sensor or button level.
REQ-002 Parameter ACK_TIMEOUT, default 255, is the maximum number of cycles to wait for Busy to rise after a strobe.
REQ-003 Clk  in  1  single clock; all state changes on the rising edge.
REQ-004 nReset  in  1  asynchronous, active-low reset.
REQ-005 CoinSense  in  3  raw coin sensors: bit0 = 1 unit, bit1 = 5 units, bit2 = 10 units.
REQ-006 StartBtn  in  1  raw start button.
REQ-007 CancelBtn  in  1  raw cancel button.
REQ-008 Busy  in  1  high while the charging station is counting down.
REQ-009 Coin  out  3  tier code presented to the station.
REQ-010 ModeEnable  out  1  one-cycle strobe qualifying Coin.
REQ-011 Credit  out  5  current credit in units, 0..30.
REQ-012 Reject  out  1  one-cycle pulse when a coin is refused.
REQ-013 Refund  out  1  one-cycle pulse when credit is returned.
REQ-014 RefundAmt  out  5  units returned; valid only while Refund is high.

Function
REQ-015 Each raw input SHALL pass through a debouncer; an event is a debounced 0->1 edge, at most one per physical press.
REQ-016 The FSM SHALL have states IDLE, COLLECT, SETUP, STROBE, ARMED, RUN.
REQ-017 In IDLE or COLLECT, a single coin event SHALL add its value to Credit on the next cycle and enter COLLECT.
REQ-018 A coin event SHALL be refused (Reject pulse, Credit unchanged) when:
- it would push Credit above 30;
- two or more coin events occur in the same cycle (all of them are refused);
- the FSM is in SETUP, STROBE, ARMED or RUN.
REQ-019 Start in COLLECT with Credit > 0 SHALL latch the tier into Coin and enter SETUP; Start with Credit = 0 SHALL be ignored.
REQ-020 Tier mapping: Credit 1-4 -> 3'b001; 5-9 -> 3'b010; 10-19 -> 3'b011; 20-30 -> 3'b100.
REQ-021 Coin SHALL be stable for the SETUP cycle, the STROBE cycle and all of ARMED and RUN.
- ModeEnable SHALL be high only in STROBE, for exactly one cycle.
- Credit SHALL be cleared in STROBE, with the consumed amount held internally.
REQ-022 ARMED SHALL move to RUN when Busy is high.
- If Busy has not risen within ACK_TIMEOUT cycles, the block SHALL pulse Refund with RefundAmt = the consumed amount and return to IDLE.
REQ-023 RUN SHALL return to IDLE on Busy falling; Coin SHALL return to 3'b000 on entering IDLE.
REQ-024 Cancel in COLLECT SHALL pulse Refund with RefundAmt = Credit, clear Credit, and enter IDLE; Cancel in any other state SHALL be ignored.
REQ-025 Simultaneous events in COLLECT:
- Cancel beats Start and coins; coins arriving in the same cycle are rejected.
- A coin event beats Start, so Start is ignored and the coin is counted.
REQ-026 ModeEnable, Reject and Refund SHALL never assert in the same cycle as reset deassertion.

Reset
REQ-027 While nReset is low, the FSM SHALL be IDLE and Coin = 0, ModeEnable = 0, Credit = 0, Reject = 0, Refund = 0, RefundAmt = 0, with debouncers and the timeout counter cleared.
REQ-028 Reset mid-operation SHALL discard credit without a Refund pulse.

Structure
REQ-029 Tier codes, coin unit values, the credit cap (30) and the FSM state encoding SHALL live in the shared package charging_pkg.
REQ-030 The debouncer SHALL be a sub-module, coin_debounce, instantiated five times.

Verification
REQ-031 Insert 5 then 10 units, press Start -> Credit = 15, Coin = 3'b011, ModeEnable pulses 1 cycle, Credit = 0; Busy high then low -> IDLE with Coin = 0.
REQ-032 Insert 10, 10, 10, then 1 -> Credit = 30, the 1-unit coin gives a Reject pulse, and Credit stays 30.
REQ-033 Insert 1 and 5 in the same cycle -> Reject, Credit = 0; then insert 5, Cancel -> Refund with RefundAmt = 5, Credit = 0.
REQ-034 Credit 7, Start, Busy held low -> after ACK_TIMEOUT cycles, Refund with RefundAmt = 7, IDLE.
REQ-035 Credit 4, Start and Cancel in the same cycle -> Refund with RefundAmt = 4, no ModeEnable.
REQ-036 nReset low during ARMED -> all outputs 0 immediately, no Refund after release.

Source files
------------

// File: rtl/charging_pkg.sv
// Shared definitions for the coin acceptor: FSM encoding, tier codes,
// coin unit values, the credit cap and the debounced event bundle.
package charging_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_ARMED   = 3'd4,
    ST_RUN     = 3'd5
  } st_e;

  localparam int unsigned NUM_SENSE = 5;  // 3 coin sensors + start + cancel

  localparam logic [2:0] TIER_NONE = 3'b000;
  localparam logic [2:0] TIER_1    = 3'b001;  // credit 1-4
  localparam logic [2:0] TIER_2    = 3'b010;  // credit 5-9
  localparam logic [2:0] TIER_3    = 3'b011;  // credit 10-19
  localparam logic [2:0] TIER_4    = 3'b100;  // credit 20-30

  localparam logic [4:0] COIN_VAL_0 = 5'd1;
  localparam logic [4:0] COIN_VAL_1 = 5'd5;
  localparam logic [4:0] COIN_VAL_2 = 5'd10;
  localparam logic [4:0] CREDIT_MAX = 5'd30;

  // Debounced 0->1 edges, one cycle each.
  typedef struct packed {
    logic       cancel;
    logic       start;
    logic [2:0] coin;
  } evt_t;

  function automatic logic [2:0] tier_of(input logic [4:0] credit);
    if (credit == 5'd0)       tier_of = TIER_NONE;
    else if (credit < 5'd5)   tier_of = TIER_1;
    else if (credit < 5'd10)  tier_of = TIER_2;
    else if (credit < 5'd20)  tier_of = TIER_3;
    else                      tier_of = TIER_4;
  endfunction

  // Value of a single coin event; caller guarantees at most one bit set.
  function automatic logic [4:0] coin_val(input logic [2:0] coin);
    coin_val = ({5{coin[0]}} & COIN_VAL_0) |
               ({5{coin[1]}} & COIN_VAL_1) |
               ({5{coin[2]}} & COIN_VAL_2);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Single-input debouncer. The accepted level flips only after the raw input
// has disagreed with it for DEBOUNCE_CYCLES consecutive samples; Rise pulses
// for one cycle when the accepted level goes 0->1.
//   Clk, nReset : clock, async active-low reset
//   Raw         : raw sensor/button
//   Rise        : one-cycle debounced rising-edge event
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Raw,
  output logic Rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          stable;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (Raw != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      stable <= 1'b0;
      cnt    <= '0;
      Rise   <= 1'b0;
    end else begin
      Rise <= flip & Raw;
      if (Raw == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= Raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front-end for a charging station. Debounces three coin
// sensors and two buttons, accumulates credit (cap 30), and on Start hands
// a tier code to the station with a one-cycle ModeEnable strobe, then waits
// for the station's Busy handshake.
//   Clk, nReset : clock, async active-low reset
//   CoinSense   : raw coin sensors (1/5/10 units)
//   StartBtn    : raw start button
//   CancelBtn   : raw cancel button
//   Busy        : station counting down
//   Coin        : tier code to station
//   ModeEnable  : one-cycle strobe qualifying Coin
//   Credit      : current credit in units
//   Reject      : coin refused pulse
//   Refund      : credit returned pulse, RefundAmt valid with it
module coin_acceptor
  import charging_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [2:0] CoinSense,
  input  logic       StartBtn,
  input  logic       CancelBtn,
  input  logic       Busy,
  output logic [2:0] Coin,
  output logic       ModeEnable,
  output logic [4:0] Credit,
  output logic       Reject,
  output logic       Refund,
  output logic [4:0] RefundAmt
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // ---- debouncers, one per raw input ----
  logic [NUM_SENSE-1:0] raw_vec;
  logic [NUM_SENSE-1:0] rise_vec;
  evt_t                 ev;

  assign raw_vec = {CancelBtn, StartBtn, CoinSense};
  assign ev      = evt_t'(rise_vec);

  for (genvar i = 0; i < NUM_SENSE; i++) begin : g_deb
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .Clk   (Clk),
      .nReset(nReset),
      .Raw   (raw_vec[i]),
      .Rise  (rise_vec[i])
    );
  end

  // ---- state ----
  st_e           state, state_nxt;
  logic [4:0]    credit, credit_nxt;
  logic [4:0]    consumed, consumed_nxt;
  logic [2:0]    coin_q, coin_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          reject_nxt, refund_nxt;
  logic [4:0]    refamt_nxt;

  logic       any_coin, multi_coin;
  logic [5:0] sum;

  assign any_coin   = |ev.coin;
  assign multi_coin = (ev.coin[0] & ev.coin[1]) | (ev.coin[0] & ev.coin[2]) |
                      (ev.coin[1] & ev.coin[2]);
  assign sum        = {1'b0, credit} + {1'b0, coin_val(ev.coin)};

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      credit    <= '0;
      consumed  <= '0;
      coin_q    <= TIER_NONE;
      tmo       <= '0;
      Reject    <= 1'b0;
      Refund    <= 1'b0;
      RefundAmt <= '0;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      consumed  <= consumed_nxt;
      coin_q    <= coin_nxt;
      tmo       <= tmo_nxt;
      Reject    <= reject_nxt;
      Refund    <= refund_nxt;
      RefundAmt <= refamt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    consumed_nxt = consumed;
    coin_nxt     = coin_q;
    tmo_nxt      = tmo;
    reject_nxt   = 1'b0;
    refund_nxt   = 1'b0;
    refamt_nxt   = '0;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (state == ST_COLLECT && ev.cancel) begin
          // Cancel wins; any coin landing in the same cycle is bounced.
          refund_nxt = 1'b1;
          refamt_nxt = credit;
          credit_nxt = '0;
          reject_nxt = any_coin;
          state_nxt  = ST_IDLE;
        end else if (any_coin) begin
          // A coin (even a refused one) masks Start in this cycle.
          if (multi_coin || sum > {1'b0, CREDIT_MAX}) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = sum[4:0];
            state_nxt  = ST_COLLECT;
          end
        end else if (state == ST_COLLECT && ev.start && credit != 5'd0) begin
          coin_nxt  = tier_of(credit);
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        reject_nxt   = any_coin;
        consumed_nxt = credit;
        credit_nxt   = '0;   // reads 0 throughout STROBE
        state_nxt    = ST_STROBE;
      end
      ST_STROBE: begin
        reject_nxt = any_coin;
        tmo_nxt    = '0;
        state_nxt  = ST_ARMED;
      end
      ST_ARMED: begin
        reject_nxt = any_coin;
        if (Busy) begin
          state_nxt = ST_RUN;
        end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
          // Station never acknowledged: give the money back.
          refund_nxt   = 1'b1;
          refamt_nxt   = consumed;
          consumed_nxt = '0;
          coin_nxt     = TIER_NONE;
          state_nxt    = ST_IDLE;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      ST_RUN: begin
        reject_nxt = any_coin;
        if (!Busy) begin
          consumed_nxt = '0;
          coin_nxt     = TIER_NONE;
          state_nxt    = ST_IDLE;
        end
      end
      default: begin
        coin_nxt  = TIER_NONE;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign Coin       = coin_q;
  assign Credit     = credit;
  assign ModeEnable = (state == ST_STROBE);

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [2:0] CoinSense = '0;
  logic       StartBtn = 1'b0;
  logic       CancelBtn = 1'b0;
  logic       Busy = 1'b0;
  logic [2:0] Coin;
  logic       ModeEnable;
  logic [4:0] Credit;
  logic       Reject;
  logic       Refund;
  logic [4:0] RefundAmt;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(TMO)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .CoinSense (CoinSense),
    .StartBtn  (StartBtn),
    .CancelBtn (CancelBtn),
    .Busy      (Busy),
    .Coin      (Coin),
    .ModeEnable(ModeEnable),
    .Credit    (Credit),
    .Reject    (Reject),
    .Refund    (Refund),
    .RefundAmt (RefundAmt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rej;
    logic       rf;
    logic       me;
    logic [4:0] amt;
    logic [2:0] coin;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  me_cyc = 0;
  int  ref_cyc = 0;
  int  ref_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input logic rej, input logic rf, input logic me,
                             input logic [4:0] amt, input logic [2:0] coin);
    mk = '{rej: rej, rf: rf, me: me, amt: amt, coin: coin};
  endfunction

  always @(posedge Clk) cyc++;

  // Every pulse cycle must match the next expected event in order.
  always @(negedge Clk) begin
    ev_t obs, exp;
    if (nReset && (Reject || Refund || ModeEnable)) begin
      obs = {Reject, Refund, ModeEnable, RefundAmt, Coin};
      if (ModeEnable) me_cyc = cyc;
      if (Refund) begin ref_cyc = cyc; ref_cnt++; end
      if (sb.size() == 0) chk("spurious", 32'(obs), 32'd0);
      else begin
        exp = sb.pop_front();
        chk("event", 32'(obs), 32'(exp));
      end
    end
  end

  // m = {cancel, start, coin[2:0]}
  task automatic press(input logic [4:0] m);
    @(posedge Clk); #1;
    {CancelBtn, StartBtn, CoinSense} = m;
    repeat (DEB + 2) @(posedge Clk);
    #1;
    {CancelBtn, StartBtn, CoinSense} = '0;
    repeat (DEB + 2) @(posedge Clk);
    #1;
  endtask

  initial begin
    int base;
    bit seen;

    // reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_credit", 32'(Credit), 32'd0);
    chk("rst_coin", 32'(Coin), 32'd0);
    chk("rst_pulses", 32'({ModeEnable, Reject, Refund}), 32'd0);
    chk("rst_amt", 32'(RefundAmt), 32'd0);
    @(negedge Clk); nReset = 1'b1;
    #1 chk("rel_pulses", 32'({ModeEnable, Reject, Refund}), 32'd0);

    // 5 + 10, Start, Busy handshake
    press(5'b00010); chk("c5", 32'(Credit), 32'd5);
    press(5'b00100); chk("c15", 32'(Credit), 32'd15);
    sb.push_back(mk(0, 0, 1, 5'd0, 3'b011));
    press(5'b01000);
    chk("strobe_clr", 32'(Credit), 32'd0);
    chk("armed_coin", 32'(Coin), 32'd3);
    Busy = 1'b1; repeat (3) @(posedge Clk); #1;
    chk("run_coin", 32'(Coin), 32'd3);
    Busy = 1'b0; repeat (3) @(posedge Clk); #1;
    chk("idle_coin", 32'(Coin), 32'd0);

    // cap at 30
    press(5'b00100); press(5'b00100); press(5'b00100);
    chk("c30", 32'(Credit), 32'd30);
    sb.push_back(mk(1, 0, 0, 5'd0, 3'b000));
    press(5'b00001);
    chk("cap_hold", 32'(Credit), 32'd30);
    sb.push_back(mk(0, 1, 0, 5'd30, 3'b000));
    press(5'b10000);
    chk("cancel30", 32'(Credit), 32'd0);

    // two coins at once, then 5 and cancel
    sb.push_back(mk(1, 0, 0, 5'd0, 3'b000));
    press(5'b00011);
    chk("multi", 32'(Credit), 32'd0);
    press(5'b00010); chk("c5b", 32'(Credit), 32'd5);
    sb.push_back(mk(0, 1, 0, 5'd5, 3'b000));
    press(5'b10000);
    chk("cancel5", 32'(Credit), 32'd0);

    // credit 7, Start, Busy never rises
    press(5'b00010); press(5'b00001); press(5'b00001);
    chk("c7", 32'(Credit), 32'd7);
    sb.push_back(mk(0, 0, 1, 5'd0, 3'b010));
    sb.push_back(mk(0, 1, 0, 5'd7, 3'b000));
    base = ref_cnt;
    press(5'b01000);
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge Clk); #1;
      if (ref_cnt != base) seen = 1;
    end
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_len", 32'(ref_cyc - me_cyc), 32'(TMO + 1));
    chk("tmo_coin", 32'(Coin), 32'd0);

    // credit 4, Start+Cancel together
    press(5'b00001); press(5'b00001); press(5'b00001); press(5'b00001);
    chk("c4", 32'(Credit), 32'd4);
    sb.push_back(mk(0, 1, 0, 5'd4, 3'b000));
    press(5'b11000);
    chk("sc_credit", 32'(Credit), 32'd0);

    // reset while ARMED
    press(5'b00100);
    sb.push_back(mk(0, 0, 1, 5'd0, 3'b011));
    press(5'b01000);
    chk("pre_rst_coin", 32'(Coin), 32'd3);
    nReset = 1'b0;
    #1;
    chk("arst_out", 32'({Coin, ModeEnable, Credit, Reject, Refund, RefundAmt}), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); nReset = 1'b1;
    #1 chk("rel2_pulses", 32'({ModeEnable, Reject, Refund}), 32'd0);
    repeat (TMO + 10) @(posedge Clk);
    #1;
    chk("post_rst_credit", 32'(Credit), 32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
